// File: rtl/multicycle_core_ctrl_if.sv
// Fetch and data memory handshake bundle for the multi-cycle core sequencer.
// master = sequencer side, slave = memory side.
interface multicycle_core_ctrl_if #(
  parameter int unsigned XLEN = 64
);
  logic            ifu_req_valid;
  logic            ifu_req_ready;
  logic [XLEN-1:0] ifu_addr;
  logic            ifu_rsp_valid;
  logic [31:0]     ifu_rsp_inst;
  logic            lsu_req_valid;
  logic            lsu_req_ready;
  logic            lsu_req_wen;
  logic            lsu_rsp_valid;
  logic [XLEN-1:0] lsu_rsp_rdata;

  modport master (
    output ifu_req_valid, ifu_addr, lsu_req_valid, lsu_req_wen,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst,
    input  lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata
  );

  modport slave (
    input  ifu_req_valid, ifu_addr, lsu_req_valid, lsu_req_wen,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_inst,
    output lsu_req_ready, lsu_rsp_valid, lsu_rsp_rdata
  );
endinterface

// File: rtl/multicycle_core_ctrl.sv
// Multi-cycle RV64 sequencer: fetch/execute/memory/writeback over valid-ready memories.
// Optional PERF_CNT_EN builds the 64-bit cycle and retired-instruction counters.
module multicycle_core_ctrl #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
  parameter int unsigned     TIMEOUT  = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_core_ctrl_if.master mem,
  output logic [31:0]          inst,
  input  logic                 dec_is_load,
  input  logic                 dec_is_store,
  input  logic                 dec_is_ebreak,
  input  logic                 dec_illegal,
  input  logic [XLEN-1:0]      dnpc,
  input  logic [XLEN-1:0]      a0,
  output logic [XLEN-1:0]      load_data,
  output logic                 reg_wen,
  output logic [XLEN-1:0]      pc,
  output logic                 retired,
  output logic                 halted,
  output logic                 trap_good,
  output logic                 error,
  output logic [63:0]          cyc_cnt,
  output logic [63:0]          instret_cnt
);
  localparam int unsigned TMO_W = 8;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  typedef enum logic [3:0] {
    S_IDLE, S_IF, S_IF_WAIT, S_EX, S_MEM, S_MEM_WAIT, S_WB, S_HALT, S_ERR
  } state_e;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [XLEN-1:0]  load_data_q, load_data_d;
  logic             is_load_q, is_load_d;
  logic             is_store_q, is_store_d;
  logic             trap_good_q, trap_good_d;
  logic             ifu_req_valid_q, ifu_req_valid_d;
  logic             lsu_req_valid_q, lsu_req_valid_d;
  logic             lsu_req_wen_q, lsu_req_wen_d;
  logic             reg_wen_q, reg_wen_d;
  logic             retired_q, retired_d;
  logic             halted_q, halted_d;
  logic             error_q, error_d;
  logic             wait_st;
  logic             hs_done;

  // Next-state, datapath latches and registered-output decode
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    load_data_d = load_data_q;
    is_load_d   = is_load_q;
    is_store_d  = is_store_q;
    trap_good_d = trap_good_q;
    wait_st     = 1'b0;
    hs_done     = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_IF;
      S_IF: begin
        wait_st = 1'b1;
        if (mem.ifu_req_ready) begin
          hs_done = 1'b1;
          state_d = S_IF_WAIT;
        end
      end
      S_IF_WAIT: begin
        wait_st = 1'b1;
        if (mem.ifu_rsp_valid) begin
          hs_done = 1'b1;
          inst_d  = mem.ifu_rsp_inst;
          state_d = S_EX;
        end
      end
      S_EX: begin
        if (dec_is_ebreak) begin
          trap_good_d = (a0 == '0);
          state_d     = S_HALT;
        end else if (dec_illegal || (dec_is_load && dec_is_store)) begin
          state_d = S_ERR;
        end else begin
          is_load_d  = dec_is_load;
          is_store_d = dec_is_store;
          state_d    = (dec_is_load || dec_is_store) ? S_MEM : S_WB;
        end
      end
      S_MEM: begin
        wait_st = 1'b1;
        if (mem.lsu_req_ready) begin
          hs_done = 1'b1;
          state_d = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        wait_st = 1'b1;
        if (mem.lsu_rsp_valid) begin
          hs_done = 1'b1;
          if (is_load_q) load_data_d = mem.lsu_rsp_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        pc_d    = dnpc;
        state_d = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    // A handshake in the final allowed cycle takes precedence over the timeout
    if (wait_st && !hs_done && (tmo_q == TMO_W'(TIMEOUT - 1))) state_d = S_ERR;

    if (state_d != state_q) tmo_d = '0;
    else if (wait_st)       tmo_d = tmo_q + TMO_W'(1);

    ifu_req_valid_d = (state_d == S_IF);
    lsu_req_valid_d = (state_d == S_MEM);
    lsu_req_wen_d   = (state_d == S_MEM) && is_store_d;
    reg_wen_d       = (state_d == S_WB) && !is_store_d;
    retired_d       = (state_d == S_WB);
    halted_d        = (state_d == S_HALT);
    error_d         = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      tmo_q           <= '0;
      pc_q            <= RESET_PC;
      inst_q          <= NOP;
      load_data_q     <= '0;
      is_load_q       <= 1'b0;
      is_store_q      <= 1'b0;
      trap_good_q     <= 1'b0;
      ifu_req_valid_q <= 1'b0;
      lsu_req_valid_q <= 1'b0;
      lsu_req_wen_q   <= 1'b0;
      reg_wen_q       <= 1'b0;
      retired_q       <= 1'b0;
      halted_q        <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmo_q           <= tmo_d;
      pc_q            <= pc_d;
      inst_q          <= inst_d;
      load_data_q     <= load_data_d;
      is_load_q       <= is_load_d;
      is_store_q      <= is_store_d;
      trap_good_q     <= trap_good_d;
      ifu_req_valid_q <= ifu_req_valid_d;
      lsu_req_valid_q <= lsu_req_valid_d;
      lsu_req_wen_q   <= lsu_req_wen_d;
      reg_wen_q       <= reg_wen_d;
      retired_q       <= retired_d;
      halted_q        <= halted_d;
      error_q         <= error_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [63:0] cyc_cnt_q, cyc_cnt_d;
  logic [63:0] instret_cnt_q, instret_cnt_d;

  // Cycle count freezes once the core has stopped
  always_comb begin
    cyc_cnt_d     = cyc_cnt_q;
    instret_cnt_d = instret_cnt_q + 64'(retired_q);
    if (state_q != S_HALT && state_q != S_ERR) cyc_cnt_d = cyc_cnt_q + 64'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt_q     <= '0;
      instret_cnt_q <= '0;
    end else begin
      cyc_cnt_q     <= cyc_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cyc_cnt     = cyc_cnt_q;
  assign instret_cnt = instret_cnt_q;
`else
  assign cyc_cnt     = '0;
  assign instret_cnt = '0;
`endif

  assign mem.ifu_req_valid = ifu_req_valid_q;
  assign mem.ifu_addr      = pc_q;
  assign mem.lsu_req_valid = lsu_req_valid_q;
  assign mem.lsu_req_wen   = lsu_req_wen_q;
  assign inst              = inst_q;
  assign load_data         = load_data_q;
  assign reg_wen           = reg_wen_q;
  assign pc                = pc_q;
  assign retired           = retired_q;
  assign halted            = halted_q;
  assign trap_good         = trap_good_q;
  assign error             = error_q;
endmodule

// File: tb/tb_multicycle_core_ctrl.sv
// Bench for multicycle_core_ctrl: per-instruction timing schedules drive reactive memories
// and predict every output cycle by cycle; directed cases pin latency, halt, error and reset.
module tb_multicycle_core_ctrl;
  localparam int          TMO      = 255;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;
`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef enum int {K_ALU, K_LOAD, K_STORE, K_EBREAK, K_ILLEGAL, K_LDST} kind_e;
  typedef struct {
    kind_e       kind;
    int          d1, d2, d3, d4;
    logic [31:0] iw;
    logic [63:0] dnpc, rdata, a0;
    int          abort_c;
  } plan_t;

  logic        clk, rst;
  logic [31:0] inst;
  logic        dec_is_load, dec_is_store, dec_is_ebreak, dec_illegal;
  logic [63:0] dnpc, a0, load_data, pc, cyc_cnt, instret_cnt;
  logic        reg_wen, retired, halted, trap_good, error;

  multicycle_core_ctrl_if #(.XLEN(64)) mif ();

  multicycle_core_ctrl dut (
    .clk(clk), .rst(rst), .mem(mif), .inst(inst),
    .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_ebreak(dec_is_ebreak), .dec_illegal(dec_illegal),
    .dnpc(dnpc), .a0(a0), .load_data(load_data), .reg_wen(reg_wen), .pc(pc),
    .retired(retired), .halted(halted), .trap_good(trap_good), .error(error),
    .cyc_cnt(cyc_cnt), .instret_cnt(instret_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Architectural model state carried between instructions
  logic [63:0] pc_m, ld_m, cyc_m, ret_m;
  logic [31:0] inst_m;

  // What the DUT was seen doing during the last instruction
  int obs_ret_c, obs_ifv, obs_regwen, obs_err_c;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc"},        pc, RESET_PC);
    chk({tag, "_ifu_addr"},  mif.ifu_addr, RESET_PC);
    chk({tag, "_inst"},      64'(inst), 64'h13);
    chk({tag, "_load_data"}, load_data, 64'h0);
    chk({tag, "_ifu_valid"}, 64'(mif.ifu_req_valid), 64'h0);
    chk({tag, "_lsu_valid"}, 64'(mif.lsu_req_valid), 64'h0);
    chk({tag, "_reg_wen"},   64'(reg_wen), 64'h0);
    chk({tag, "_retired"},   64'(retired), 64'h0);
    chk({tag, "_halted"},    64'(halted), 64'h0);
    chk({tag, "_trap_good"}, 64'(trap_good), 64'h0);
    chk({tag, "_error"},     64'(error), 64'h0);
    chk({tag, "_cyc"},       cyc_cnt, 64'h0);
    chk({tag, "_instret"},   instret_cnt, 64'h0);
  endtask

  // Called at a negedge; returns at the negedge of the first IF cycle after release.
  task automatic do_reset(input bit late_rsp);
    rst = 1'b0;
    mif.ifu_req_ready = 1'b0;
    mif.lsu_req_ready = 1'b0;
    mif.ifu_rsp_valid = late_rsp;
    mif.lsu_rsp_valid = late_rsp;
    mif.lsu_rsp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    #1;
    check_reset_vals("rst_async");
    @(negedge clk);
    check_reset_vals("rst_hold");
    rst = 1'b1;
    check_reset_vals("rst_release");
    pc_m   = RESET_PC;
    inst_m = 32'h13;
    ld_m   = '0;
    cyc_m  = 64'd1;
    ret_m  = '0;
    @(negedge clk);
  endtask

  function automatic plan_t mk(input kind_e k, input int d1, input int d2, input int d3, input int d4);
    plan_t p;
    p.kind    = k;
    p.d1      = d1;
    p.d2      = d2;
    p.d3      = d3;
    p.d4      = d4;
    p.iw      = (k == K_EBREAK) ? 32'h0010_0073 : 32'($urandom);
    p.dnpc    = {32'($urandom), 32'($urandom)};
    p.rdata   = {32'($urandom), 32'($urandom)};
    p.a0      = {32'($urandom), 32'($urandom)};
    p.abort_c = -1;
    return p;
  endfunction

  // Runs one instruction from its first IF cycle; delays >= TMO mean the handshake never comes.
  task automatic run(input plan_t p);
    int if_hi, rsp_if, e, mem_lo, mem_hi, m, rsp_ls, wb, halt_c, err_c, last;
    bit hx, ex, lv, is_mem, in_if_win, in_ls_win;
    logic [31:0] r;
    rsp_if = -1; e = -1; mem_lo = -1; mem_hi = -1; m = -1; rsp_ls = -1;
    wb = -1; halt_c = -1; err_c = -1;
    is_mem = (p.kind == K_LOAD) || (p.kind == K_STORE);
    if (p.d1 >= TMO) begin
      if_hi = TMO - 1;
      err_c = TMO;
    end else begin
      if_hi = p.d1;
      if (p.d2 >= TMO) err_c = p.d1 + 1 + TMO;
      else begin
        rsp_if = p.d1 + 1 + p.d2;
        e      = rsp_if + 1;
        if (p.kind == K_EBREAK) halt_c = e + 1;
        else if (p.kind == K_ILLEGAL || p.kind == K_LDST) err_c = e + 1;
        else if (!is_mem) wb = e + 1;
        else begin
          mem_lo = e + 1;
          if (p.d3 >= TMO) begin
            mem_hi = e + TMO;
            err_c  = e + 1 + TMO;
          end else begin
            mem_hi = e + 1 + p.d3;
            m      = mem_hi + 1;
            if (p.d4 >= TMO) err_c = m + TMO;
            else begin
              rsp_ls = m + p.d4;
              wb     = rsp_ls + 1;
            end
          end
        end
      end
    end
    last = (wb >= 0) ? wb : (((halt_c >= 0) ? halt_c : err_c) + 3);

    obs_ret_c = -1; obs_ifv = 0; obs_regwen = 0; obs_err_c = -1;
    dec_is_load   = (p.kind == K_LOAD) || (p.kind == K_LDST);
    dec_is_store  = (p.kind == K_STORE) || (p.kind == K_LDST);
    dec_is_ebreak = (p.kind == K_EBREAK);
    dec_illegal   = (p.kind == K_ILLEGAL);
    dnpc = p.dnpc;
    a0   = p.a0;

    for (int c = 0; c <= last; c++) begin
      hx = (halt_c >= 0) && (c >= halt_c);
      ex = (err_c >= 0) && (c >= err_c);
      lv = (mem_lo >= 0) && (c >= mem_lo) && (c <= mem_hi);
      chk("ifu_req_valid", 64'(mif.ifu_req_valid), 64'(c <= if_hi));
      chk("ifu_addr", mif.ifu_addr, pc_m);
      chk("pc", pc, pc_m);
      chk("inst", 64'(inst), 64'((rsp_if >= 0 && c > rsp_if) ? p.iw : inst_m));
      chk("lsu_req_valid", 64'(mif.lsu_req_valid), 64'(lv));
      if (lv) chk("lsu_req_wen", 64'(mif.lsu_req_wen), 64'(p.kind == K_STORE));
      chk("load_data", load_data,
          (p.kind == K_LOAD && rsp_ls >= 0 && c > rsp_ls) ? p.rdata : ld_m);
      chk("reg_wen", 64'(reg_wen), 64'(c == wb && p.kind != K_STORE));
      chk("retired", 64'(retired), 64'(c == wb));
      chk("halted", 64'(halted), 64'(hx));
      chk("trap_good", 64'(trap_good), 64'(hx && p.a0 == 64'h0));
      chk("error", 64'(error), 64'(ex));
      chk("cyc_cnt", cyc_cnt, PERF ? cyc_m : 64'h0);
      chk("instret_cnt", instret_cnt, PERF ? ret_m : 64'h0);

      if (retired) obs_ret_c = c;
      if (mif.ifu_req_valid) obs_ifv++;
      if (reg_wen) obs_regwen++;
      if (error && obs_err_c < 0) obs_err_c = c;
      if (!hx && !ex) cyc_m = cyc_m + 64'd1;
      if (c == wb) ret_m = ret_m + 64'd1;
      if (c == p.abort_c) break;

      r = $urandom;
      mif.ifu_req_ready = (c == p.d1) ? 1'b1 : ((c < p.d1) ? 1'b0 : r[0]);
      in_if_win = (p.d1 < TMO) && (c > p.d1) && (rsp_if < 0 || c < rsp_if);
      if (rsp_if >= 0 && c == rsp_if) begin
        mif.ifu_rsp_valid = 1'b1;
        mif.ifu_rsp_inst  = p.iw;
      end else begin
        mif.ifu_rsp_valid = in_if_win ? 1'b0 : (r[3:2] == 2'b00);
        mif.ifu_rsp_inst  = 32'($urandom);
      end
      if (p.d3 < TMO && c == mem_hi) mif.lsu_req_ready = 1'b1;
      else if (lv)                   mif.lsu_req_ready = 1'b0;
      else                           mif.lsu_req_ready = r[1];
      in_ls_win = (m >= 0) && (c >= m) && (rsp_ls < 0 || c < rsp_ls);
      if (rsp_ls >= 0 && c == rsp_ls) begin
        mif.lsu_rsp_valid = 1'b1;
        mif.lsu_rsp_rdata = p.rdata;
      end else begin
        mif.lsu_rsp_valid = in_ls_win ? 1'b0 : (r[5:4] == 2'b00);
        mif.lsu_rsp_rdata = {32'($urandom), 32'($urandom)};
      end
      @(negedge clk);
    end

    if (wb >= 0 && p.abort_c < 0) begin
      pc_m   = p.dnpc;
      inst_m = p.iw;
      if (p.kind == K_LOAD) ld_m = p.rdata;
    end
  endtask

  task automatic random_burst(input int n);
    plan_t p;
    kind_e k;
    int sel;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 5);
      k = (sel < 3) ? K_ALU : ((sel < 5) ? K_LOAD : K_STORE);
      if (sel == 5) k = K_STORE;
      p = mk(k, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0) ? $urandom_range(4, 20) : $urandom_range(0, 3));
      run(p);
    end
  endtask

  initial begin
    plan_t p;
    rst = 1'b0;
    dec_is_load = 1'b0; dec_is_store = 1'b0; dec_is_ebreak = 1'b0; dec_illegal = 1'b0;
    dnpc = '0; a0 = '0;
    mif.ifu_req_ready = 1'b0; mif.ifu_rsp_valid = 1'b0; mif.ifu_rsp_inst = '0;
    mif.lsu_req_ready = 1'b0; mif.lsu_rsp_valid = 1'b0; mif.lsu_rsp_rdata = '0;
    @(negedge clk);
    do_reset(1'b0);

    // addi at the reset PC with zero-wait memories
    p = mk(K_ALU, 0, 0, 0, 0);
    p.iw = 32'h0010_0513;
    p.dnpc = 64'h8000_0004;
    run(p);
    chk("addi_retire_cycle", 64'(obs_ret_c + 1), 64'd4);
    chk("addi_reg_wen_pulses", 64'(obs_regwen), 64'd1);
    chk("addi_pc_after", pc, 64'h8000_0004);
    chk("addi_inst_latched", 64'(inst), 64'h0010_0513);

    // fetch ready withheld for 5 cycles
    p = mk(K_ALU, 5, 0, 0, 0);
    run(p);
    chk("stall_ifu_valid_cycles", 64'(obs_ifv), 64'd6);
    chk("stall_retire_cycle", 64'(obs_ret_c + 1), 64'd9);

    p = mk(K_LOAD, 0, 0, 0, 0);
    p.rdata = 64'hDEAD_BEEF_00C0_FFEE;
    run(p);
    chk("load_retire_cycle", 64'(obs_ret_c + 1), 64'd6);
    chk("load_reg_wen_pulses", 64'(obs_regwen), 64'd1);
    chk("load_data_literal", load_data, 64'hDEAD_BEEF_00C0_FFEE);

    p = mk(K_STORE, 0, 0, 0, 0);
    run(p);
    chk("store_retire_cycle", 64'(obs_ret_c + 1), 64'd6);
    chk("store_reg_wen_pulses", 64'(obs_regwen), 64'd0);

    random_burst(30);

    // response in the last allowed wait cycle still wins over the timeout
    p = mk(K_ALU, 0, TMO - 1, 0, 0);
    run(p);
    chk("edge_no_error", 64'(obs_err_c), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("edge_retire_cycle", 64'(obs_ret_c + 1), 64'd258);

    p = mk(K_EBREAK, 0, 0, 0, 0);
    p.a0 = 64'd0;
    run(p);
    chk("ebreak0_halted", 64'(halted), 64'd1);
    chk("ebreak0_trap_good", 64'(trap_good), 64'd1);
    chk("ebreak0_no_fetch", 64'(mif.ifu_req_valid), 64'd0);
    do_reset(1'b0);

    p = mk(K_EBREAK, 1, 2, 0, 0);
    p.a0 = 64'd5;
    run(p);
    chk("ebreak5_halted", 64'(halted), 64'd1);
    chk("ebreak5_trap_good", 64'(trap_good), 64'd0);
    do_reset(1'b0);

    p = mk(K_ALU, 0, 1000, 0, 0);
    run(p);
    chk("ifu_rsp_timeout_cycle", 64'(obs_err_c), 64'd256);
    do_reset(1'b0);

    p = mk(K_ALU, 1000, 0, 0, 0);
    run(p);
    chk("ifu_ready_timeout_cycle", 64'(obs_err_c), 64'd255);
    do_reset(1'b0);

    p = mk(K_LDST, 0, 0, 0, 0);
    run(p);
    chk("ldst_error_cycle", 64'(obs_err_c), 64'd3);
    do_reset(1'b0);

    p = mk(K_ILLEGAL, 0, 0, 0, 0);
    run(p);
    chk("illegal_error_cycle", 64'(obs_err_c), 64'd3);
    do_reset(1'b0);

    p = mk(K_LOAD, 0, 0, 0, 1000);
    run(p);
    chk("lsu_rsp_timeout_cycle", 64'(obs_err_c), 64'd259);
    do_reset(1'b0);

    random_burst(10);

    // reset while waiting on a load response, with the response arriving during/after reset
    p = mk(K_LOAD, 0, 0, 0, 5);
    p.abort_c = 5;
    run(p);
    do_reset(1'b1);
    p = mk(K_ALU, 0, 0, 0, 0);
    run(p);
    chk("post_reset_retire_cycle", 64'(obs_ret_c + 1), 64'd4);
    chk("post_reset_load_data", load_data, 64'd0);

    random_burst(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
